// File: rtl/pri_enc_pkg.sv
// rtl/pri_enc_pkg.sv - shared constants and index-width helper for pri_enc_irq
package pri_enc_pkg;

  localparam logic PRI_FIXED = 1'b0;
  localparam logic PRI_RR    = 1'b1;

  function automatic int pri_enc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// rtl/pri_enc_comb.sv - combinational N-to-W highest-set-bit encoder with any-bit flag
module pri_enc_comb
  import pri_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = pri_enc_clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic         o_any,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_any = |i_vec;
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/pri_enc_irq.sv
// rtl/pri_enc_irq.sv - registered priority encoder with pending capture, mask and valid/ack
// Define PRI_ENC_RR_EN to add the i_rr port and round-robin pointer.
module pri_enc_irq
  import pri_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = pri_enc_clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_mask,
  input  logic         i_ack,
`ifdef PRI_ENC_RR_EN
  input  logic         i_rr,
`endif
  output logic         o_valid,
  output logic [W-1:0] o_y,
  output logic [N-1:0] o_pend
);

  logic [N-1:0] r_pend;
  logic         r_valid;
  logic [W-1:0] r_y;

  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_nxt;
  logic [N-1:0] w_cand;
  logic         w_sel;
  logic [N-1:0] w_enc_in;
  logic         w_any;
  logic [W-1:0] w_enc_idx;
  logic [W-1:0] w_win;

  // Set wins over clear because req is OR-ed in after the clear
  assign w_clr      = (r_valid && i_ack) ? (N'(1) << r_y) : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | i_req;
  assign w_cand     = w_pend_nxt & ~i_mask;
  assign w_sel      = !r_valid || i_ack;

`ifdef PRI_ENC_RR_EN
  logic [W-1:0] r_ptr;
  logic         w_rr_mode;
  logic [N-1:0] w_rot;

  function automatic int wrap_add(input int a, input int b);
    int s;
    s = a + b;
    if (s >= N) s = s - N;
    return s;
  endfunction

  assign w_rr_mode = (i_rr == PRI_RR);

  // Rotate so that cand[ptr] lands on the top bit and the search descends from ptr
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = w_cand[W'(wrap_add(int'(r_ptr) + 1, j))];
    end
  end

  assign w_enc_in = w_rr_mode ? w_rot : w_cand;
  assign w_win    = w_rr_mode ? W'(wrap_add(int'(r_ptr) + 1, int'(w_enc_idx))) : w_enc_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= W'(N - 1);
    end else if (w_sel && w_any && w_rr_mode) begin
      r_ptr <= (w_win == '0) ? W'(N - 1) : w_win - 1'b1;
    end
  end
`else
  assign w_enc_in = w_cand;
  assign w_win    = w_enc_idx;
`endif

  pri_enc_comb #(.N(N)) u_enc (
    .i_vec (w_enc_in),
    .o_any (w_any),
    .o_idx (w_enc_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_y     <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_sel) begin
        r_valid <= w_any;
        r_y     <= w_any ? w_win : '0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_y     = r_y;
  assign o_pend  = r_pend;

endmodule

// File: tb/tb_pri_enc_irq.sv
// tb/tb_pri_enc_irq.sv - table-driven scoreboard bench for pri_enc_irq (N=8)
module tb_pri_enc_irq;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       ev;
    logic [2:0] ey;
    logic [7:0] ep;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       rr;
  logic       valid;
  logic [2:0] y;
  logic [7:0] pend;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t exp_q[$];
  vec_t tbl[26];

  pri_enc_irq #(.N(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_mask  (mask),
    .i_ack   (ack),
`ifdef PRI_ENC_RR_EN
    .i_rr    (rr),
`endif
    .o_valid (valid),
    .o_y     (y),
    .o_pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input string tag, input vec_t v);
    vec_t e;
    req  = v.req;
    mask = v.mask;
    ack  = v.ack;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, " valid"}, {7'd0, valid}, {7'd0, e.ev});
    chk({tag, " y"},     {5'd0, y},     {5'd0, e.ey});
    chk({tag, " pend"},  pend,          e.ep);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00; mask = 8'h00; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        req    mask   ack  ev  ey    ep
    tbl[0]  = '{8'h05, 8'h00, 1'b0, 1'b1, 3'd2, 8'h05};
    tbl[1]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01};
    tbl[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[3]  = '{8'h04, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04};
    tbl[4]  = '{8'h80, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    tbl[5]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[11] = '{8'h06, 8'h04, 1'b0, 1'b1, 3'd1, 8'h06};
    tbl[12] = '{8'h00, 8'h04, 1'b1, 1'b0, 3'd0, 8'h04};
    tbl[13] = '{8'h00, 8'h04, 1'b1, 1'b0, 3'd0, 8'h04};
    tbl[14] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04};
    tbl[15] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[16] = '{8'h08, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08};
    tbl[17] = '{8'h08, 8'h00, 1'b1, 1'b1, 3'd3, 8'h08};
    tbl[18] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[19] = '{8'hFF, 8'h00, 1'b0, 1'b1, 3'd7, 8'hFF};
    tbl[20] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd6, 8'h7F};
    tbl[21] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd5, 8'h3F};
    tbl[22] = '{8'h00, 8'h20, 1'b0, 1'b1, 3'd5, 8'h3F};
    tbl[23] = '{8'h00, 8'h20, 1'b1, 1'b1, 3'd4, 8'h1F};
    tbl[24] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h1F};
    tbl[25] = '{8'h40, 8'h00, 1'b0, 1'b1, 3'd4, 8'h5F};

    rr   = 1'b0;
    rst  = 1'b1;
    req  = 8'hFF;
    mask = 8'h00;
    ack  = 1'b0;
    run("reset0", '{8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00});
    run("reset1", '{8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
    rst = 1'b0;
    req = 8'h00;

    for (int i = 0; i < 26; i++) begin
      run($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset while a grant is held, away from any clock edge
    rst = 1'b1;
    #1;
    chk("async_rst valid", {7'd0, valid}, 8'h00);
    chk("async_rst y",     {5'd0, y},     8'h00);
    chk("async_rst pend",  pend,          8'h00);
    #1;
    req = 8'h01;
    rst = 1'b0;
    run("post_rst0", '{8'h01, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01});
    run("post_rst1", '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});
    run("idle_ack",  '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00});

`ifdef PRI_ENC_RR_EN
    do_reset();
    rr = 1'b1;
    run("rr0", '{8'h82, 8'h00, 1'b0, 1'b1, 3'd7, 8'h82});
    run("rr1", '{8'h82, 8'h00, 1'b1, 1'b1, 3'd1, 8'h82});
    run("rr2", '{8'h82, 8'h00, 1'b1, 1'b1, 3'd7, 8'h82});
    run("rr3", '{8'h82, 8'h00, 1'b1, 1'b1, 3'd1, 8'h82});
    do_reset();
    rr = 1'b0;
`endif
    run("fix0", '{8'h82, 8'h00, 1'b0, 1'b1, 3'd7, 8'h82});
    run("fix1", '{8'h82, 8'h00, 1'b1, 1'b1, 3'd7, 8'h82});
    run("fix2", '{8'h82, 8'h00, 1'b1, 1'b1, 3'd7, 8'h82});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
